// File: rtl/wake_word_emitter.sv
// Programmable character emitter: streams a small ASCII buffer over a valid/ready
// handshake for len x (rep+1) transfers, then pulses done. The buffer resets to "Alexa".
module wake_word_emitter #(
    parameter int MAX_LEN = 8,
    parameter int CHAR_W  = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]          wr_data,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic [3:0]                 cfg_rep,
    input  logic                       start,
    input  logic                       ready,
    output logic [CHAR_W-1:0]          ascii,
    output logic                       valid,
    output logic                       busy,
    output logic                       done
);
    localparam int AW = $clog2(MAX_LEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] LEN_RST = (MAX_LEN < 5) ? LEN_MAX : (AW+1)'(5);

    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        return (l > LEN_MAX) ? LEN_MAX : l;
    endfunction

    function automatic logic [CHAR_W-1:0] init_char(input int i);
        case (i)
            0:       return CHAR_W'(7'h41);
            1:       return CHAR_W'(7'h6C);
            2:       return CHAR_W'(7'h65);
            3:       return CHAR_W'(7'h78);
            4:       return CHAR_W'(7'h61);
            default: return CHAR_W'(7'h20);
        endcase
    endfunction

    logic [1:0]        state;
    logic [AW-1:0]     idx;
    logic [3:0]        pass;
    logic [3:0]        rep;
    logic [AW:0]       len;
    logic [CHAR_W-1:0] char_buf [MAX_LEN];

    logic [AW:0] start_len;
    logic        last_char;

    assign start_len = clamp_len(cfg_len);
    assign last_char = ({1'b0, idx} == (len - (AW+1)'(1)));

    // Outputs decode straight from state so an async reset clears them at once.
    assign valid = (state == SEND);
    assign ascii = valid ? char_buf[idx] : '0;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            pass  <= '0;
            rep   <= '0;
            len   <= LEN_RST;
            for (int i = 0; i < MAX_LEN; i++) begin
                char_buf[i] <= init_char(i);
            end
        end else begin
            // Writes only land in IDLE, so the buffer is frozen for the whole run.
            if (wr_en && (state == IDLE)) begin
                char_buf[wr_addr] <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= start_len;
                        rep   <= cfg_rep;
                        idx   <= '0;
                        pass  <= '0;
                        state <= (start_len == '0) ? DONE : SEND;
                    end
                end
                SEND: begin
                    if (ready) begin
                        if (last_char) begin
                            idx  <= '0;
                            pass <= pass + 4'd1;
                            if (pass == rep) begin
                                state <= DONE;
                            end
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wake_word_emitter.sv
// Bench for wake_word_emitter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based reference model.
module tb_wake_word_emitter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [6:0] wr_data = '0;
    logic [3:0] cfg_len = '0;
    logic [3:0] cfg_rep = '0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [6:0] ascii;
    logic       valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    // Reference model: buffer contents, queue of characters still to send, done flag.
    logic [6:0] mbuf [8];
    logic [6:0] q [$];
    bit         done_m = 1'b0;

    logic [6:0] exp5 [5] = '{7'h41, 7'h6C, 7'h65, 7'h78, 7'h61};
    logic [6:0] hi [3]   = '{7'h48, 7'h69, 7'h21};

    wake_word_emitter #(.MAX_LEN(8), .CHAR_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_len(cfg_len), .cfg_rep(cfg_rep), .start(start), .ready(ready),
        .ascii(ascii), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic load_alexa();
        for (int i = 0; i < 8; i++) mbuf[i] = 7'h20;
        for (int i = 0; i < 5; i++) mbuf[i] = exp5[i];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    initial load_alexa();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            done_m = 1'b0;
            load_alexa();
        end else if (q.size() == 0 && !done_m) begin
            if (wr_en) mbuf[wr_addr] = wr_data;
            if (start) begin
                int l;
                l = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
                for (int p = 0; p <= int'(cfg_rep); p++)
                    for (int i = 0; i < l; i++) q.push_back(mbuf[i]);
                if (l == 0) done_m = 1'b1;
            end
        end else if (q.size() > 0) begin
            if (ready) begin
                void'(q.pop_front());
                if (q.size() == 0) done_m = 1'b1;
            end
        end else begin
            done_m = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(valid), 32'(q.size() > 0));
        chk("ascii", 32'(ascii), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("busy",  32'(busy),  32'((q.size() > 0) || done_m));
        chk("done",  32'(done),  32'(done_m));
        if (done) done_seen++;
    end

    initial begin
        int base;
        int n;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("rst_ascii", 32'(ascii), 0);
        #2 rst_n = 1'b1;

        @(negedge clk);
        cfg_len = 4'd5; cfg_rep = 4'd0; ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); start = 1'b0;
            if (k <= 5) chk("basic_char", 32'(ascii), 32'(exp5[k-1]));
            if (k == 6) chk("basic_done", 32'(done), 1);
            if (k == 7) chk("basic_idle", 32'(busy), 0);
        end

        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk); start = 1'b0;
            ready = !(k == 2 || k == 3);
            if (k == 4) chk("bp_hold", 32'(ascii), 32'h6C);
            if (k == 7) chk("bp_last", 32'(ascii), 32'h61);
            if (k == 8) chk("bp_done", 32'(done), 1);
            if (k == 9) chk("bp_idle", 32'(busy), 0);
        end

        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = hi[i];
            if (i < 2) @(negedge clk);
        end
        cfg_len = 4'd3; cfg_rep = 4'd2; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk); start = 1'b0;
            wr_en = (k == 2); wr_addr = 3'd0; wr_data = 7'h5A;
            if (k == 1)  chk("hi_first", 32'(ascii), 32'h48);
            if (k == 4)  chk("hi_wrap",  32'(ascii), 32'h48);
            if (k == 6)  chk("hi_p2",    32'(ascii), 32'h21);
            if (k == 9)  chk("hi_last",  32'(ascii), 32'h21);
            if (k == 10) chk("hi_done",  32'(done), 1);
            if (k == 11) chk("hi_idle",  32'(busy), 0);
        end

        cfg_len = 4'd0; cfg_rep = 4'd0; start = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 1) begin
                chk("len0_done",  32'(done), 1);
                chk("len0_busy",  32'(busy), 1);
                chk("len0_valid", 32'(valid), 0);
            end
            if (k == 2) chk("len0_idle", 32'(busy), 0);
        end

        cfg_len = 4'd12; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 1)  chk("clamp_first", 32'(ascii), 32'h48);
            if (k == 6)  chk("clamp_e5",    32'(ascii), 32'h20);
            if (k == 8)  chk("clamp_e7",    32'(ascii), 32'h20);
            if (k == 9)  chk("clamp_done",  32'(done), 1);
            if (k == 10) chk("clamp_idle",  32'(busy), 0);
        end

        cfg_len = 4'd5; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_busy",  32'(busy),  0);
        chk("mrst_done",  32'(done),  0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 1) chk("mrst_a0", 32'(ascii), 32'h41);
            if (k == 5) chk("mrst_a4", 32'(ascii), 32'h61);
            if (k == 6) chk("mrst_done_pulse", 32'(done), 1);
        end

        cfg_len = 4'd5; cfg_rep = 4'd1; start = 1'b1;
        base = done_seen;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 11);
            if (k == 3) cfg_len = 4'd2;
            if (k == 10) chk("ign_last", 32'(ascii), 32'h61);
            if (k == 11) chk("ign_done", 32'(done), 1);
            if (k == 12) begin
                chk("ign_idle",  32'(busy), 0);
                chk("ign_valid", 32'(valid), 0);
            end
        end
        #1 chk("ign_done_count", 32'(done_seen - base), 1);

        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                start = 1'b0; wr_en = 1'b0;
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end else begin
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_addr = 3'($urandom);
                wr_data = 7'($urandom);
                start   = ($urandom_range(0, 5) == 0);
                cfg_len = 4'($urandom_range(0, 12));
                cfg_rep = 4'($urandom_range(0, 3));
                ready   = ($urandom_range(0, 3) != 0);
            end
        end

        @(negedge clk);
        start = 1'b0; wr_en = 1'b0; ready = 1'b1;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 32'(busy), 0);

        cfg_len = 4'd8; cfg_rep = 4'd15; start = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 128) chk("long_valid", 32'(valid), 1);
            if (k == 129) chk("long_done",  32'(done), 1);
            if (k == 130) chk("long_idle",  32'(busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
